// File: rtl/generic_hdr_demux.sv
// Header + AXI-Stream payload demultiplexer: the select bitfield in the header chooses one of M_COUNT ports.
// Optional macro GENERIC_HDR_DEMUX_DROP_CNT_EN enables the saturating dropped-frame counter.
module generic_hdr_demux #(
  parameter int M_COUNT      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1,
  parameter int HEADER_WIDTH = 12,
  parameter int SEL_OFFSET   = 0,
  parameter int SEL_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_hdr_valid,
  output logic                               s_hdr_ready,
  input  logic [HEADER_WIDTH*8-1:0]          s_hdr,
  input  logic [DATA_WIDTH-1:0]              s_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]              s_payload_axis_tkeep,
  input  logic                               s_payload_axis_tvalid,
  output logic                               s_payload_axis_tready,
  input  logic                               s_payload_axis_tlast,
  input  logic [USER_WIDTH-1:0]              s_payload_axis_tuser,
  output logic [M_COUNT-1:0]                 m_hdr_valid,
  input  logic [M_COUNT-1:0]                 m_hdr_ready,
  output logic [M_COUNT*HEADER_WIDTH*8-1:0]  m_hdr,
  output logic [M_COUNT*DATA_WIDTH-1:0]      m_payload_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]      m_payload_axis_tkeep,
  output logic [M_COUNT-1:0]                 m_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]                 m_payload_axis_tready,
  output logic [M_COUNT-1:0]                 m_payload_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0]      m_payload_axis_tuser,
  output logic [15:0]                        drop_count
);

  typedef enum logic [1:0] {IDLE, FRAME, WAIT_HDR, DROP} state_t;

  state_t                   state, state_next;
  logic [SEL_WIDTH-1:0]     sel_reg, sel_in;
  logic                     sel_in_range;
  logic                     hdr_valid_reg, hdr_valid_next;
  logic [HEADER_WIDTH*8-1:0] hdr_reg;
  logic                     s_hdr_ready_reg, s_hdr_ready_next;
  logic                     hdr_accept, hdr_hs;
  logic                     m_hdr_ready_sel, m_tready_sel;
  logic                     beat_in, int_valid;
  logic                     tready_int_reg, tready_int_early;
  logic                     out_valid, out_valid_next, temp_valid, temp_valid_next;
  logic                     store_int_to_out, store_int_to_temp, store_temp_to_out;
  logic [DATA_WIDTH-1:0]    out_data, temp_data;
  logic [KEEP_WIDTH-1:0]    out_keep, temp_keep;
  logic                     out_last, temp_last;
  logic [USER_WIDTH-1:0]    out_user, temp_user;

  assign sel_in       = s_hdr[SEL_OFFSET +: SEL_WIDTH];
  assign sel_in_range = 32'(sel_in) < 32'(M_COUNT);
  assign hdr_accept   = s_hdr_valid && s_hdr_ready_reg;
  assign hdr_hs       = hdr_valid_reg && m_hdr_ready_sel;
  assign beat_in      = s_payload_axis_tvalid && s_payload_axis_tready;
  assign int_valid    = beat_in && (state == FRAME);

  always_comb begin
    m_hdr_ready_sel = 1'b0;
    m_tready_sel    = 1'b0;
    for (int unsigned i = 0; i < M_COUNT; i++) begin
      if (sel_reg == SEL_WIDTH'(i)) begin
        m_hdr_ready_sel = m_hdr_ready[i];
        m_tready_sel    = m_payload_axis_tready[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (hdr_accept) state_next = sel_in_range ? FRAME : DROP;
      FRAME:    if (beat_in && s_payload_axis_tlast)
                  state_next = (!hdr_valid_reg || hdr_hs) ? IDLE : WAIT_HDR;
      WAIT_HDR: if (hdr_hs) state_next = IDLE;
      DROP:     if (beat_in && s_payload_axis_tlast) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    s_hdr_ready           = s_hdr_ready_reg;
    s_payload_axis_tready = ((state == FRAME) && tready_int_reg) || (state == DROP);
    m_hdr_valid           = '0;
    m_payload_axis_tvalid = '0;
    for (int unsigned i = 0; i < M_COUNT; i++) begin
      if (sel_reg == SEL_WIDTH'(i)) begin
        m_hdr_valid[i]           = hdr_valid_reg;
        m_payload_axis_tvalid[i] = out_valid;
      end
    end
  end

  assign m_hdr                = {M_COUNT{hdr_reg}};
  assign m_payload_axis_tdata = {M_COUNT{out_data}};
  assign m_payload_axis_tlast = {M_COUNT{out_last}};
  assign m_payload_axis_tkeep = (KEEP_ENABLE != 0) ? {M_COUNT{out_keep}} : '1;
  assign m_payload_axis_tuser = (USER_ENABLE != 0) ? {M_COUNT{out_user}} : '0;

  // Skid buffer: the early ready is registered, so a temp slot catches the one beat in flight.
  assign tready_int_early = m_tready_sel || (!temp_valid && (!out_valid || !int_valid));

  always_comb begin
    out_valid_next    = out_valid;
    temp_valid_next   = temp_valid;
    store_int_to_out  = 1'b0;
    store_int_to_temp = 1'b0;
    store_temp_to_out = 1'b0;
    if (tready_int_reg) begin
      if (m_tready_sel || !out_valid) begin
        out_valid_next   = int_valid;
        store_int_to_out = 1'b1;
      end else begin
        temp_valid_next   = int_valid;
        store_int_to_temp = 1'b1;
      end
    end else if (m_tready_sel) begin
      out_valid_next    = temp_valid;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_comb begin
    hdr_valid_next = hdr_valid_reg;
    if (hdr_hs) hdr_valid_next = 1'b0;
    if (hdr_accept && sel_in_range) hdr_valid_next = 1'b1;
    // Next header only once the previous frame has fully left both output paths.
    s_hdr_ready_next = (state_next == IDLE) && !hdr_accept && !hdr_valid_next &&
                       !out_valid_next && !temp_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg         <= '0;
      hdr_valid_reg   <= 1'b0;
      s_hdr_ready_reg <= 1'b0;
      tready_int_reg  <= 1'b0;
      out_valid       <= 1'b0;
      temp_valid      <= 1'b0;
    end else begin
      if (hdr_accept) sel_reg <= sel_in;
      hdr_valid_reg   <= hdr_valid_next;
      s_hdr_ready_reg <= s_hdr_ready_next;
      tready_int_reg  <= tready_int_early;
      out_valid       <= out_valid_next;
      temp_valid      <= temp_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_accept) hdr_reg <= s_hdr;
    if (store_int_to_out) begin
      out_data <= s_payload_axis_tdata;
      out_keep <= s_payload_axis_tkeep;
      out_last <= s_payload_axis_tlast;
      out_user <= s_payload_axis_tuser;
    end else if (store_temp_to_out) begin
      out_data <= temp_data;
      out_keep <= temp_keep;
      out_last <= temp_last;
      out_user <= temp_user;
    end
    if (store_int_to_temp) begin
      temp_data <= s_payload_axis_tdata;
      temp_keep <= s_payload_axis_tkeep;
      temp_last <= s_payload_axis_tlast;
      temp_user <= s_payload_axis_tuser;
    end
  end

`ifdef GENERIC_HDR_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_reg <= '0;
    else if ((state == DROP) && beat_in && s_payload_axis_tlast && (drop_cnt_reg != '1))
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign drop_count = drop_cnt_reg;
`else
  assign drop_count = '0;
`endif

endmodule
